// File: rtl/div_share_ctrl.sv
// Two-requester, round-robin front end for a shared combinational 16/8 divider.
// Operands are held in registers for a CORE_LAT-cycle settle window, then the result is registered.
module div_share_core (
  input  logic [15:0] n,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  output logic [7:0]  r
);
  logic [8:0] rem;

  // Full 16-stage restoring array. The remainder is always exact, and q keeps
  // the low 8 quotient bits, so it wraps when n[15:8] >= d.
  always_comb begin
    rem = '0;
    q   = '0;
    for (int i = 15; i >= 0; i--) begin
      rem = {rem[7:0], n[i]};
      if (rem >= {1'b0, d}) begin
        rem = rem - {1'b0, d};
        if (i < 8) q[i[2:0]] = 1'b1;
      end
    end
    r = rem[7:0];
  end
endmodule

module div_share_ctrl #(
  parameter int CORE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_n,
  input  logic [7:0]  req0_d,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_n,
  input  logic [7:0]  req1_d,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_q,
  output logic [7:0]  rsp_r,
  output logic        rsp_dz,
  output logic        rsp_ovf,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(CORE_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] opn_q, opn_d;
  logic [7:0]  opd_q, opd_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic        vld_q, vld_d;
  logic [7:0]  rq_q, rq_d;
  logic [7:0]  rr_q, rr_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;

  logic        grant0, grant1, take, gid;
  logic [15:0] sel_n;
  logic [7:0]  sel_d;
  logic [7:0]  core_q, core_r;

  // The core sees only the operand registers, so its inputs are quiet across WAIT.
  div_share_core u_core (
    .n (opn_q),
    .d (opd_q),
    .q (core_q),
    .r (core_r)
  );

  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_q);
    grant1 = req1_valid && (!req0_valid || !last_q);
  end

  assign req0_ready = rst_n && (state_q == IDLE) && grant0;
  assign req1_ready = rst_n && (state_q == IDLE) && grant1;
  assign take       = req0_ready || req1_ready;
  assign gid        = req1_ready;
  assign sel_n      = gid ? req1_n : req0_n;
  assign sel_d      = gid ? req1_d : req0_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opn_d   = opn_q;
    opd_d   = opd_q;
    id_d    = id_q;
    last_d  = last_q;
    vld_d   = vld_q;
    rq_d    = rq_q;
    rr_d    = rr_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (take) begin
        opn_d  = sel_n;
        opd_d  = sel_d;
        id_d   = gid;
        last_d = gid;
        if (sel_d == 8'd0) begin
          state_d = DONE;
          vld_d   = 1'b1;
          rq_d    = 8'hFF;
          rr_d    = sel_n[7:0];
          dz_d    = 1'b1;
          ovf_d   = 1'b0;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = DONE;
        vld_d   = 1'b1;
        rq_d    = core_q;
        rr_d    = core_r;
        dz_d    = 1'b0;
        ovf_d   = (opn_q[15:8] >= opd_q);
      end
      DONE: if (rsp_ready) begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opn_q   <= '0;
      opd_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      vld_q   <= 1'b0;
      rq_q    <= '0;
      rr_q    <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opn_q   <= opn_d;
      opd_q   <= opd_d;
      id_q    <= id_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      rq_q    <= rq_d;
      rr_q    <= rr_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_q     = rq_q;
  assign rsp_r     = rr_q;
  assign rsp_dz    = dz_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed + randomized bench for div_share_ctrl against an arithmetic reference model.
module tb_div_share_ctrl;
  localparam int CL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0v = 1'b0, r1v = 1'b0, rsp_ready = 1'b0;
  logic [15:0] r0n = '0, r1n = '0;
  logic [7:0]  r0d = '0, r1d = '0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_dz, rsp_ovf, busy;
  logic [7:0]  rsp_q, rsp_r;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          id;
    logic [15:0] n;
    logic [7:0]  d;
    int          acc;
  } op_t;

  div_share_ctrl #(.CORE_LAT(CL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(req0_ready), .req0_n(r0n), .req0_d(r0d),
    .req1_valid(r1v), .req1_ready(req1_ready), .req1_n(r1n), .req1_d(r1d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mq(input logic [15:0] n, input logic [7:0] d);
    if (d == 8'd0) return 8'hFF;
    return 8'(int'(n) / int'(d));
  endfunction

  function automatic logic [7:0] mr(input logic [15:0] n, input logic [7:0] d);
    if (d == 8'd0) return n[7:0];
    return 8'(int'(n) % int'(d));
  endfunction

  function automatic logic movf(input logic [15:0] n, input logic [7:0] d);
    return (d != 8'd0) && (int'(n) / 256 >= int'(d));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input bit id, input logic [15:0] n, input logic [7:0] d);
    check({tag, "_id"},  rsp_id,  id);
    check({tag, "_q"},   rsp_q,   mq(n, d));
    check({tag, "_r"},   rsp_r,   mr(n, d));
    check({tag, "_dz"},  rsp_dz,  d == 8'd0);
    check({tag, "_ovf"}, rsp_ovf, movf(n, d));
  endtask

  // One operation from one requester, response taken immediately.
  task automatic single(input bit id, input logic [15:0] n, input logic [7:0] d, input string tag);
    int t, w;
    @(negedge clk);
    if (id) begin r1v = 1'b1; r1n = n; r1d = d; end
    else    begin r0v = 1'b1; r0n = n; r0d = d; end
    #1;
    check({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    t = cyc;
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0;
    w = 0;
    while (!rsp_valid && w < 50) begin @(negedge clk); w++; end
    check({tag, "_lat"}, cyc - t, (d == 8'd0) ? 1 : CL + 1);
    check_rsp(tag, id, n, d);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_clr"}, {rsp_valid, busy}, 0);
  endtask

  initial begin
    op_t exp_q[$];
    op_t op;
    int  last, prev_acc, t, w, extra;
    bit  g;

    // Reset: ready stays low even with both requesters valid.
    r0v = 1'b1; r1v = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf, busy}, 0);
    r0v = 1'b0; r1v = 1'b0;
    rst_n = 1'b1;

    // Arbitration under contention with zero backpressure.
    last = 1; prev_acc = -1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4 * (CL + 2) + 2; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("arb_spurious", 1, 0);
        else begin
          op = exp_q.pop_front();
          check("arb_rsp_lat", cyc - op.acc, CL + 1);
          check_rsp("arb", op.id, op.n, op.d);
        end
      end
      r0v = 1'b1; r1v = 1'b1;
      r0n = 16'($urandom); r0d = 8'($urandom_range(1, 255));
      r1n = 16'($urandom); r1d = 8'($urandom_range(1, 255));
      #1;
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        check("arb_onehot", req0_ready & req1_ready, 0);
        check("arb_grant", g, (last == 0));
        last = g;
        if (prev_acc >= 0) check("arb_space", cyc - prev_acc, CL + 2);
        prev_acc = cyc;
        op.id = g; op.n = g ? r1n : r0n; op.d = g ? r1d : r0d; op.acc = cyc;
        exp_q.push_back(op);
      end
    end
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0;
    for (int k = 0; k < 2 * CL + 6; k++) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("arb_spurious", 1, 0);
        else begin
          op = exp_q.pop_front();
          check_rsp("arb_drain", op.id, op.n, op.d);
        end
      end
      @(negedge clk);
    end
    check("arb_all_rsp", exp_q.size(), 0);
    rsp_ready = 1'b0;

    // Directed cases from the plan.
    single(1'b0, 16'h03E8, 8'd7, "basic");
    single(1'b1, 16'h1234, 8'd0, "divzero");
    single(1'b0, 16'h0900, 8'd8, "ovf");
    single(1'b1, 16'hFFFF, 8'd1, "maxovf");
    single(1'b0, 16'h00FE, 8'd255, "small");

    // Random singles, zero divisors mixed in.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      single(1'($urandom_range(0, 1)), 16'($urandom), rd, "rand");
    end

    // Backpressure: response held six cycles while requester inputs churn.
    @(negedge clk);
    r0v = 1'b1; r0n = 16'h7A31; r0d = 8'd13;
    #1 check("bp_ready", req0_ready, 1);
    @(negedge clk);
    r0v = 1'b0;
    w = 0;
    while (!rsp_valid && w < 50) begin @(negedge clk); w++; end
    check("bp_valid", rsp_valid, 1);
    for (int k = 0; k < 6; k++) begin
      r0v = 1'b1; r1v = 1'b1;
      r0n = 16'($urandom); r0d = 8'($urandom);
      r1n = 16'($urandom); r1d = 8'($urandom);
      #1;
      check("bp_noready", {req0_ready, req1_ready}, 0);
      check("bp_hold_valid", rsp_valid, 1);
      check_rsp("bp_hold", 1'b0, 16'h7A31, 8'd13);
      @(negedge clk);
    end
    r0v = 1'b0; r1v = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) extra++;
      @(negedge clk);
    end
    check("bp_one_rsp", extra, 0);

    // Reset mid-WAIT discards the operation and restores requester-0 priority.
    r0v = 1'b1; r0n = 16'h4321; r0d = 8'd5;
    #1 check("rst_acc", req0_ready, 1);
    t = cyc;
    @(negedge clk);
    check("rst_busy_wait", busy, 1);
    r0v = 1'b1; r1v = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf, busy}, 0);
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0;
    rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < CL + 6; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) extra++;
    end
    check("rst_no_rsp", extra, 0);
    r0v = 1'b1; r1v = 1'b1;
    #1;
    check("rst_prio", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
